fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 66 ++++++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch buffer entry, pc_sel encodings.
// Branch target helper is shared so every user computes the same address.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
  } fetch_entry_t;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_REG  = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP = 2'b10;

  function automatic word_t branch_target(input word_t npc, input logic [15:0] imm);
    return npc + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order {instr, npc} buffer; head visible combinationally, writes land next edge.
// Caller must not push when full or pop when empty; flush wins over push/pop.
module fetch_buffer
  import cpu_types_pkg::*;
(
  input  logic         CLK,
  input  logic         nRST,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) entry0_d = push_dat_i;
          else                 entry1_d = push_dat_i;
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          // entry0 always holds the head, so a pop shifts entry1 forward
          if (count_q == 2'd1) begin
            entry0_d = push_dat_i;
          end else begin
            entry0_d = entry1_q;
            entry1_d = push_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = entry0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with a 2-entry prefetch buffer; ihit to instr_valid is 1 cycle when empty.
// iREN drops while the buffer is full or the core is halted; redirect/halt flush the buffer.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        iREN,
  output word_t       iaddr,
  input  logic        ihit,
  input  word_t       iload,
  output word_t       instr,
  output word_t       npc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  pc_sel,
  input  logic        brEn,
  input  logic [15:0] br_imm,
  input  logic [25:0] jaddr,
  input  word_t       rs_data,
  input  logic        halt,
  output logic        halted
);

  localparam word_t PC_RESET_ALIGNED = PC_RESET & 32'hFFFF_FFFC;

  word_t        fetch_pc_q, fetch_pc_d;
  logic         halted_q, halted_d;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_dat;
  logic         consume, redirect, halt_take, push, pop, flush;
  word_t        target;

  assign iREN        = !halted_q && (count < 2'd2);
  assign instr_valid = !halted_q && (count != 2'd0);
  assign consume     = instr_valid && instr_ready;
  assign halt_take   = consume && halt;
  assign redirect    = consume && ((pc_sel == PC_SEL_REG) || (pc_sel == PC_SEL_JUMP) ||
                                   ((pc_sel == PC_SEL_SEQ) && brEn));

  always_comb begin
    target = branch_target(head.npc, br_imm);
    case (pc_sel)
      PC_SEL_JUMP: target = {head.npc[31:28], jaddr, 2'b00};
      PC_SEL_REG:  target = rs_data & 32'hFFFF_FFFC;
      default:     ;
    endcase
  end

  // A flushing cycle throws away whatever the memory returned alongside it
  assign flush    = redirect || halt_take;
  assign push     = iREN && ihit && !flush;
  assign pop      = consume && !flush;
  assign push_dat = '{instr: iload, npc: fetch_pc_q + 32'd4};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q || halt_take;
    if (halt_take)     fetch_pc_d = fetch_pc_q;
    else if (redirect) fetch_pc_d = target;
    else if (push)     fetch_pc_d = fetch_pc_q + 32'd4;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc_q <= PC_RESET_ALIGNED;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .CLK        (CLK),
    .nRST       (nRST),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (flush),
    .count_o    (count),
    .head_o     (head)
  );

  assign iaddr  = fetch_pc_q;
  assign instr  = head.instr;
  assign npc    = head.npc;
  assign halted = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pc_sel;
  logic        brEn;
  logic [15:0] br_imm;
  logic [25:0] jaddr;
  logic [31:0] rs_data;
  logic        halt;
  logic        halted;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  fetch_unit #(.PC_RESET(RST_PC)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .instr(instr), .npc(npc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_sel(pc_sel), .brEn(brEn), .br_imm(br_imm), .jaddr(jaddr), .rs_data(rs_data),
    .halt(halt), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  bit          mhalt;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_idle();
    instr_ready = 1'b1;
    ihit        = 1'b1;
    iload       = $urandom & 32'h0FFF_FFFF;
    pc_sel      = 2'b00;
    brEn        = 1'b0;
    br_imm      = 16'($urandom);
    jaddr       = 26'($urandom);
    rs_data     = $urandom;
    halt        = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic tick();
    bit          exp_ren, exp_vld, cons;
    logic [31:0] hnpc, tgt;
    int          off;
    ent_t        e;
    @(negedge CLK);
    exp_ren = !mhalt && (mq.size() < 2);
    exp_vld = !mhalt && (mq.size() > 0);
    chk("iREN", 32'(iREN), 32'(exp_ren));
    chk("instr_valid", 32'(instr_valid), 32'(exp_vld));
    chk("iaddr", iaddr, mpc);
    chk("halted", 32'(halted), 32'(mhalt));
    if (exp_vld) begin
      chk("instr", instr, mq[0].instr);
      chk("npc", npc, mq[0].npc);
    end
    cons = exp_vld && instr_ready;
    if (cons && halt) begin
      mhalt = 1'b1;
      mq.delete();
    end else if (cons && (pc_sel == 2'd1 || pc_sel == 2'd2 || (pc_sel == 2'd0 && brEn))) begin
      hnpc = mq[0].npc;
      if (pc_sel == 2'd0) begin
        off = $signed(br_imm);
        tgt = hnpc + 32'(off * 4);
      end else if (pc_sel == 2'd2) begin
        tgt = (hnpc & 32'hF000_0000) + 32'(jaddr) * 32'd4;
      end else begin
        tgt = (rs_data / 4) * 4;
      end
      mpc = tgt;
      mq.delete();
    end else begin
      if (cons) void'(mq.pop_front());
      if (exp_ren && ihit) begin
        e.instr = iload;
        e.npc   = mpc + 32'd4;
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; asserts reset with a concurrent ihit, checks, releases.
  task automatic do_reset();
    nRST  = 1'b0;
    ihit  = 1'b1;
    iload = $urandom;
    #2;
    chk("rst_iaddr", iaddr, RST_PC);
    chk("rst_iREN", 32'(iREN), 32'd1);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_npc", npc, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    mq.delete();
    mpc   = RST_PC;
    mhalt = 1'b0;
  endtask

  task automatic run_until_npc(input logic [31:0] tgt);
    for (int g = 0; g < 40 && !(mq.size() > 0 && mq[0].npc == tgt); g++) begin
      set_idle();
      tick();
    end
  endtask

  task automatic run_until_valid();
    for (int g = 0; g < 40 && !(mq.size() > 0 && !mhalt); g++) begin
      set_idle();
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    nRST = 1'b0;
    set_idle();
    @(posedge CLK);
    #1;
    do_reset();

    // Straight-line fetch, first valid one cycle after release
    set_idle();
    tick();
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_npc", npc, 32'h4);
    for (int i = 0; i < 6; i++) begin
      set_idle();
      tick();
    end

    // Stall fills the buffer and holds the fetch address
    @(posedge CLK); #1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_idle();
      instr_ready = 1'b0;
      tick();
    end
    chk("stall_iaddr", iaddr, 32'h8);
    chk("stall_iREN", 32'(iREN), 32'd0);
    chk("stall_head", npc, 32'h4);
    set_idle();
    ihit = 1'b0;
    tick();
    chk("stall_second", npc, 32'h8);
    set_idle();
    tick();

    // Backward branch flushes and drops same-cycle ihit data
    do_reset();
    run_until_npc(32'h10);
    chk("br_head_npc", npc, 32'h10);
    set_idle();
    brEn   = 1'b1;
    br_imm = 16'hFFFC;
    iload  = 32'hDEAD_BEEF;
    tick();
    chk("br_iaddr", iaddr, 32'h0);
    chk("br_flushed", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      set_idle();
      tick();
      chk("br_no_stale", 32'(instr_valid && instr == 32'hDEAD_BEEF), 32'd0);
    end

    // Jump and register redirects
    do_reset();
    run_until_valid();
    set_idle();
    pc_sel  = 2'b01;
    rs_data = 32'h4000_0004;
    tick();
    run_until_npc(32'h4000_0008);
    chk("j_head_npc", npc, 32'h4000_0008);
    set_idle();
    pc_sel = 2'b10;
    jaddr  = 26'h0000040;
    tick();
    chk("j_iaddr", iaddr, 32'h4000_0100);
    run_until_valid();
    set_idle();
    pc_sel  = 2'b01;
    rs_data = 32'h0000_0203;
    tick();
    chk("jr_iaddr", iaddr, 32'h0000_0200);
    set_idle();
    pc_sel = 2'b11;
    tick();

    // Halt beats a same-cycle jump and is sticky until reset
    run_until_valid();
    set_idle();
    halt   = 1'b1;
    pc_sel = 2'b10;
    tick();
    chk("halt_set", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      set_idle();
      ihit = 1'($urandom);
      halt = 1'($urandom);
      tick();
      chk("halt_iREN", 32'(iREN), 32'd0);
    end
    do_reset();

    // Fetch PC wrap at the top of the address space
    run_until_valid();
    set_idle();
    pc_sel  = 2'b01;
    rs_data = 32'hFFFF_FFFF;
    tick();
    chk("wrap_pc", iaddr, 32'hFFFF_FFFC);
    set_idle();
    instr_ready = 1'b0;
    tick();
    chk("wrap_iaddr", iaddr, 32'h0);
    chk("wrap_npc", npc, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      ihit        = ($urandom_range(0, 9) < 6);
      iload       = $urandom;
      r           = $urandom_range(0, 19);
      pc_sel      = (r < 14) ? 2'b00 : 2'(r % 4);
      brEn        = ($urandom_range(0, 3) == 0);
      br_imm      = 16'($urandom);
      jaddr       = 26'($urandom);
      rs_data     = $urandom;
      halt        = ($urandom_range(0, 149) == 0);
      if ((mhalt && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
